// File: rtl/noc_rx_sink.sv
// noc_rx_sink: NoC receive FIFO with backpressure, FWFT head and per-source stats; define NOC_RX_SEQ_CHECK_EN for sequence checking
module noc_rx_sink #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8,
  parameter logic [1:0] LOCAL_ID = 2'b00,
  parameter int AF_MARGIN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  consume,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic [23:0]           rxCount,
  output logic [7:0]            misrouteCount,
  output logic                  overflow,
  output logic                  seqErr,
  output logic [1:0]            seqErrSrc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count, count_n, free;
  logic [AW-1:0] rd_next;
  logic [1:0] dest, src;
  logic [7:0] seq;
  logic push, pop, drop_mis, empty_after_pop;
  logic [DATA_WIDTH-1:0] head_n;
  logic [2:0][7:0] rx_cnt;
  assign dest = dataIn[15:14];
  assign src = dataIn[13:12];
  assign seq = dataIn[7:0];
  assign push = write && !full && dest == LOCAL_ID;
  assign drop_mis = write && !full && dest != LOCAL_ID;
  assign pop = consume && valid;
  assign valid = count != '0;
  assign full = count == DEPTH_C;
  assign free = DEPTH_C - count;
  assign almost_full = 32'(free) <= $unsigned(AF_MARGIN);
  assign rd_next = rd_ptr[AW-1:0] + AW'(1);
  assign empty_after_pop = pop ? count == ONE : !valid;
  assign count_n = push == pop ? count : push ? count + ONE : count - ONE;
  assign head_n = push && empty_after_pop ? dataIn : pop && count > ONE ? mem[rd_next] : dataOut;
  assign rxCount = rx_cnt;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= dataIn;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      dataOut <= '0;
      rx_cnt <= '0;
      misrouteCount <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + ONE : wr_ptr;
      rd_ptr <= pop ? rd_ptr + ONE : rd_ptr;
      count <= count_n;
      dataOut <= head_n;
      overflow <= overflow || (write && full);
      misrouteCount <= drop_mis && misrouteCount != 8'hff ? misrouteCount + 8'd1 : misrouteCount;
      for (int i = 0; i < 3; i++)
        if (push && src == 2'(i) && rx_cnt[i] != 8'hff) rx_cnt[i] <= rx_cnt[i] + 8'd1;
    end
  end
`ifdef NOC_RX_SEQ_CHECK_EN
  logic [2:0][7:0] exp_seq;
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_seq <= '0;
      seqErr <= 1'b0;
      seqErrSrc <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (push && src == 2'(i)) begin
          if (seq != exp_seq[i]) begin
            seqErr <= 1'b1;
            seqErrSrc <= src;
          end
          exp_seq[i] <= seq + 8'd1;
        end
    end
  end
`else
  assign seqErr = 1'b0;
  assign seqErrSrc = 2'b00;
`endif
endmodule

// File: tb/tb_noc_rx_sink.sv
// tb_noc_rx_sink: directed and random checks of noc_rx_sink against a queue-based reference model
module tb_noc_rx_sink;
  localparam int DEPTH = 8;
  localparam int AFM = 2;
  logic clk = 1'b0;
  logic reset, write, consume;
  logic [15:0] dataIn;
  logic full, almost_full, valid, overflow, seqErr;
  logic [15:0] dataOut;
  logic [23:0] rxCount;
  logic [7:0] misrouteCount;
  logic [1:0] seqErrSrc;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] q [$];
  int m_rx [3];
  int m_mis;
  bit m_ovf, m_serr;
  logic [1:0] m_ssrc;
  logic [7:0] m_exp [3];
  logic [15:0] m_head;
  noc_rx_sink #(.DATA_WIDTH(16), .DEPTH(DEPTH), .LOCAL_ID(2'b00), .AF_MARGIN(AFM)) dut (
    .clk(clk), .reset(reset), .write(write), .dataIn(dataIn), .full(full),
    .almost_full(almost_full), .consume(consume), .valid(valid), .dataOut(dataOut),
    .rxCount(rxCount), .misrouteCount(misrouteCount), .overflow(overflow),
    .seqErr(seqErr), .seqErrSrc(seqErrSrc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic r, input logic w, input logic [15:0] d, input logic c);
    bit was_full;
    int s;
    if (r) begin
      q.delete();
      m_rx = '{0, 0, 0};
      m_exp = '{8'd0, 8'd0, 8'd0};
      m_mis = 0;
      m_ovf = 0;
      m_serr = 0;
      m_ssrc = 2'b00;
      m_head = 16'h0;
    end else begin
      was_full = q.size() == DEPTH;
      if (c && q.size() > 0) void'(q.pop_front());
      if (w) begin
        s = int'(d[13:12]);
        if (was_full) m_ovf = 1;
        else if (d[15:14] != 2'b00) m_mis = m_mis == 255 ? 255 : m_mis + 1;
        else begin
          q.push_back(d);
          if (s < 3) begin
            m_rx[s] = m_rx[s] == 255 ? 255 : m_rx[s] + 1;
            if (d[7:0] != m_exp[s]) begin
              m_serr = 1;
              m_ssrc = d[13:12];
            end
            m_exp[s] = d[7:0] + 8'd1;
          end
        end
      end
      if (q.size() > 0) m_head = q[0];
    end
  endtask
  task automatic check_all();
    chk("valid", 32'(valid), 32'(q.size() > 0));
    chk("dataOut", 32'(dataOut), 32'(m_head));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("almost_full", 32'(almost_full), 32'((DEPTH - q.size()) <= AFM));
    chk("rxCount", 32'(rxCount), {8'h0, 8'(m_rx[2]), 8'(m_rx[1]), 8'(m_rx[0])});
    chk("misrouteCount", 32'(misrouteCount), 32'(m_mis));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef NOC_RX_SEQ_CHECK_EN
    chk("seqErr", 32'(seqErr), 32'(m_serr));
    chk("seqErrSrc", 32'(seqErrSrc), 32'(m_ssrc));
`else
    chk("seqErr", 32'(seqErr), 32'(0));
    chk("seqErrSrc", 32'(seqErrSrc), 32'(0));
`endif
  endtask
  task automatic step(input logic r, input logic w, input logic [15:0] d, input logic c);
    reset = r;
    write = w;
    dataIn = d;
    consume = c;
    @(posedge clk);
    model(r, w, d, c);
    #1;
    check_all();
  endtask
  initial begin
    logic [15:0] d;
    logic [1:0] s;
    reset = 1'b1;
    write = 1'b0;
    consume = 1'b0;
    dataIn = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_af", 32'(almost_full), 32'(0));
    step(0, 1, 16'h0000, 1);
    chk("tp1_d0", 32'(dataOut), 32'h0000);
    step(0, 1, 16'h0001, 1);
    chk("tp1_d1", 32'(dataOut), 32'h0001);
    step(0, 1, 16'h0002, 1);
    chk("tp1_d2", 32'(dataOut), 32'h0002);
    step(0, 0, 16'h0000, 1);
    chk("tp1_rx", 32'(rxCount), 32'h000003);
    chk("tp1_hold", 32'(dataOut), 32'h0002);
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 16'(i), 0);
      if (i == 4) chk("tp2_af5", 32'(almost_full), 32'(0));
      if (i == 5) chk("tp2_af6", 32'(almost_full), 32'(1));
      if (i == 6) chk("tp2_full7", 32'(full), 32'(0));
      if (i == 7) chk("tp2_full8", 32'(full), 32'(1));
    end
    chk("tp2_ovf", 32'(overflow), 32'(1));
    chk("tp2_rx", 32'(rxCount[7:0]), 32'd8);
    step(0, 1, 16'h0008, 1);
    chk("tp4_full", 32'(full), 32'(0));
    chk("tp4_head", 32'(dataOut), 32'h0001);
    chk("tp4_rx", 32'(rxCount[7:0]), 32'd8);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1);
    chk("tp4_empty", 32'(valid), 32'(0));
    step(1, 0, 0, 0);
    step(0, 1, 16'h4000, 1);
    chk("tp3_mis", 32'(misrouteCount), 32'd1);
    chk("tp3_valid", 32'(valid), 32'(0));
    chk("tp3_rx", 32'(rxCount), 32'h0);
    step(1, 0, 0, 0);
    step(0, 1, 16'h1000, 1);
    step(0, 1, 16'h1001, 1);
    step(0, 1, 16'h1003, 1);
`ifdef NOC_RX_SEQ_CHECK_EN
    chk("tp5_err", 32'(seqErr), 32'(1));
    chk("tp5_src", 32'(seqErrSrc), 32'(1));
`else
    chk("tp5_err", 32'(seqErr), 32'(0));
`endif
    chk("tp5_rx", 32'(rxCount), 32'h000300);
    step(0, 1, 16'h3055, 0);
    chk("src3_rx", 32'(rxCount), 32'h000300);
    step(0, 1, 16'h0000, 0);
    step(0, 1, 16'h2000, 0);
    step(0, 1, 16'h1004, 0);
    step(1, 0, 0, 0);
    chk("tp6_valid", 32'(valid), 32'(0));
    chk("tp6_rx", 32'(rxCount), 32'h0);
    chk("tp6_dout", 32'(dataOut), 32'h0);
    for (int i = 0; i < 260; i++) step(0, 1, {4'b0010, 4'h0, 8'(i)}, 1);
    chk("sat_rx", 32'(rxCount[23:16]), 32'd255);
    for (int i = 0; i < 260; i++) step(0, 1, 16'hC000, 1);
    chk("sat_mis", 32'(misrouteCount), 32'd255);
    for (int i = 0; i < 800; i++) begin
      s = 2'($urandom_range(0, 3));
      d = {($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, s, 4'($urandom),
           (s != 2'd3 && $urandom_range(0, 4) != 0) ? m_exp[s] : 8'($urandom)};
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, d, $urandom_range(0, 2) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
